// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared RV32I encoding constants: the descriptor op-class enumeration,
//   the seven major opcodes (shared with the main control decoder) and the
//   funct3 values that are forced for loads, stores and branches.
`timescale 1ns/1ps
package riscv_pkg;

  typedef enum logic [2:0] {
    OPC_R    = 3'd0,
    OPC_I    = 3'd1,
    OPC_LW   = 3'd2,
    OPC_SW   = 3'd3,
    OPC_BEQ  = 3'd4,
    OPC_LUI  = 3'd5,
    OPC_JAL  = 3'd6,
    OPC_RSVD = 3'd7
  } op_class_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] LW_F3  = 3'b010;
  localparam logic [2:0] SW_F3  = 3'b010;
  localparam logic [2:0] BEQ_F3 = 3'b000;

endpackage

// File: rtl/instr_pack.sv
// instr_pack
//   Purely combinational packer: turns one operation descriptor into a
//   32-bit RV32I instruction word and flags descriptors that must not be
//   written (reserved op class, and with IMM_RANGE_CHECK_EN defined,
//   immediates that do not fit their instruction field).
// Ports:
//   op_class            in  3   descriptor class (see riscv_pkg::op_class_e)
//   rd, rs1, rs2        in  5   register fields
//   funct3              in  3   R / I-ALU funct3
//   funct7              in  7   R funct7
//   imm                 in  32  signed immediate / byte offset
//   word                out 32  encoded instruction
//   bad                 out 1   descriptor rejected (nothing to write)
`timescale 1ns/1ps
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  op_class,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        bad
);

  op_class_e cls;
  assign cls = op_class_e'(op_class);

  always_comb begin
    word = 32'd0;
    case (cls)
      OPC_R:   word = {funct7, rs2, rs1, funct3, rd, OP_R};
      OPC_I:   word = {imm[11:0], rs1, funct3, rd, OP_I};
      OPC_LW:  word = {imm[11:0], rs1, LW_F3, rd, OP_LW};
      OPC_SW:  word = {imm[11:5], rs2, rs1, SW_F3, imm[4:0], OP_SW};
      OPC_BEQ: word = {imm[12], imm[10:5], rs2, rs1, BEQ_F3, imm[4:1], imm[11], OP_BEQ};
      OPC_LUI: word = {imm[31:12], rd, OP_LUI};
      OPC_JAL: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      default: word = 32'd0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // A signed value fits in N bits when every bit above bit N-1 equals the
  // sign bit, i.e. imm[31:N-1] is all zeros or all ones.
  logic fits12, fits13, fits21;
  assign fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);

  always_comb begin
    bad = 1'b0;
    case (cls)
      OPC_I, OPC_LW, OPC_SW: bad = !fits12;
      OPC_BEQ:  bad = !fits13 || imm[0];
      OPC_JAL:  bad = !fits21 || imm[0];
      OPC_LUI:  bad = (imm[11:0] != 12'd0);
      OPC_RSVD: bad = 1'b1;
      default:  bad = 1'b0;
    endcase
  end
`else
  assign bad = (cls == OPC_RSVD);
`endif

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
//   Accepts operation descriptors over a valid/ready handshake, encodes each
//   into an RV32I instruction word and writes it to consecutive word
//   addresses of instruction memory. Optional immediate range checking is
//   enabled by defining IMM_RANGE_CHECK_EN.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a program (honoured in IDLE or DONE)
//   base_addr [ADDR_W]  byte address of first word (bits [1:0] ignored)
//   length    [LEN_W]   number of words to write
//   in_valid / in_ready descriptor handshake
//   op_class, rd, rs1, rs2, funct3, funct7, imm   descriptor fields
//   imem_we, imem_addr, imem_wdata               memory write port
//   done                program complete
//   err                 sticky error (cleared by start)
`timescale 1ns/1ps
module instr_encoder #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_class,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] next_addr_reg;   // address of the next word to write
  logic [LEN_W-1:0]  remaining_reg;   // words still to be written
  logic              err_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;

  logic [31:0] packed_word;
  logic        packed_bad;
  logic        fire;

  instr_pack u_pack (
    .op_class (op_class),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .funct3   (funct3),
    .funct7   (funct7),
    .imm      (imm),
    .word     (packed_word),
    .bad      (packed_bad)
  );

  assign in_ready   = (state_reg == RUN) && (remaining_reg != '0);
  assign fire       = in_valid && in_ready;
  assign done       = (state_reg == DONE);
  assign err        = err_reg;
  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      next_addr_reg <= '0;
      remaining_reg <= '0;
      err_reg       <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
    end else begin
      we_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg     <= RUN;
            next_addr_reg <= base_addr & ~ADDR_W'(3);
            remaining_reg <= length;
            err_reg       <= 1'b0;
          end
        end
        RUN: begin
          // Once the count reaches zero the final write (if any) is on the
          // bus this cycle, so done follows one cycle later.
          if (remaining_reg == '0) begin
            state_reg <= DONE;
          end else if (fire) begin
            if (packed_bad) begin
              err_reg <= 1'b1;
            end else begin
              we_reg        <= 1'b1;
              addr_reg      <= next_addr_reg;
              wdata_reg     <= packed_word;
              next_addr_reg <= next_addr_reg + ADDR_W'(4);
              remaining_reg <= remaining_reg - LEN_W'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] length;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op_class;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        done;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(32), .LEN_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_class   (op_class),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .funct7     (funct7),
    .imm        (imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .done       (done),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Present one descriptor, wait (bounded) for in_ready, complete the
  // handshake; returns just after the handshake edge.
  task automatic send(input string tag, input logic [2:0] cls, input logic [4:0] rd_i,
                      input logic [4:0] rs1_i, input logic [4:0] rs2_i,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    op_class = cls; rd = rd_i; rs1 = rs1_i; rs2 = rs2_i;
    funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_we"},   {31'd0, imem_we}, 32'd1);
    chk({tag, "_addr"}, imem_addr, a);
    chk({tag, "_data"}, imem_wdata, d);
    $display("write %s: addr=0x%08h data=0x%08h", tag, imem_addr, imem_wdata);
  endtask

  task automatic expect_idle_outputs(input string tag);
    chk({tag, "_we"},    {31'd0, imem_we}, 32'd0);
    chk({tag, "_addr"},  imem_addr, 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_rdy"},   {31'd0, in_ready}, 32'd0);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
    chk({tag, "_err"},   {31'd0, err}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; in_valid = 1'b0;
    op_class = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    #1;
    expect_idle_outputs("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_rdy", {31'd0, in_ready}, 32'd0);

    // Program 1: addi / add / lw
    do_start(32'h100, 16'd3);
    chk("p1_rdy", {31'd0, in_ready}, 32'd1);
    send("addi", 3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
    expect_write("addi", 32'h100, 32'h00500093);
    send("add", 3'd0, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0);
    expect_write("add", 32'h104, 32'h002081B3);
    send("lw", 3'd2, 5'd2, 5'd1, 5'd0, 3'b111, 7'd0, 32'd8);
    expect_write("lw", 32'h108, 32'h0080A103);
    chk("p1_rdy_low", {31'd0, in_ready}, 32'd0);
    chk("p1_done_early", {31'd0, done}, 32'd0);
    tick();
    chk("p1_done", {31'd0, done}, 32'd1);
    chk("p1_we_off", {31'd0, imem_we}, 32'd0);

    // Program 2: sw / beq / lui / jal
    do_start(32'h200, 16'd4);
    chk("p2_done_clr", {31'd0, done}, 32'd0);
    send("sw", 3'd3, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd4);
    expect_write("sw", 32'h200, 32'h0020A223);
    send("beq", 3'd4, 5'd0, 5'd1, 5'd2, 3'b111, 7'd0, 32'hFFFFFFFC);
    expect_write("beq", 32'h204, 32'hFE208EE3);
    send("lui", 3'd5, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000);
    expect_write("lui", 32'h208, 32'h123452B7);
    send("jal", 3'd6, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8);
    expect_write("jal", 32'h20C, 32'h008000EF);
    tick();
    chk("p2_done", {31'd0, done}, 32'd1);

    // Program 3: reserved op class is consumed but not counted
    do_start(32'h300, 16'd2);
    send("rsvd", 3'd7, 5'd1, 5'd1, 5'd1, 3'b000, 7'd0, 32'd0);
    chk("rsvd_we", {31'd0, imem_we}, 32'd0);
    chk("rsvd_err", {31'd0, err}, 32'd1);
    chk("rsvd_rdy", {31'd0, in_ready}, 32'd1);
    send("p3a", 3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
    expect_write("p3a", 32'h300, 32'h00500093);
    send("p3b", 3'd0, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0);
    expect_write("p3b", 32'h304, 32'h002081B3);
    tick();
    chk("p3_done", {31'd0, done}, 32'd1);
    chk("p3_err_sticky", {31'd0, err}, 32'd1);

    // Program 4: out-of-range addi immediate
    do_start(32'h400, 16'd1);
    chk("p4_err_clr", {31'd0, err}, 32'd0);
    send("big", 3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4096);
`ifdef IMM_RANGE_CHECK_EN
    chk("big_we", {31'd0, imem_we}, 32'd0);
    chk("big_err", {31'd0, err}, 32'd1);
    send("p4ok", 3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
    expect_write("p4ok", 32'h400, 32'h00500093);
`else
    expect_write("big", 32'h400, 32'h00000093);
    chk("big_err", {31'd0, err}, 32'd0);
`endif
    tick();
    chk("p4_done", {31'd0, done}, 32'd1);

    // Program 5: address wrap; low base bits ignored
    do_start(32'hFFFFFFFE, 16'd2);
    send("wrap0", 3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
    expect_write("wrap0", 32'hFFFFFFFC, 32'h00500093);
    send("wrap1", 3'd2, 5'd2, 5'd1, 5'd0, 3'b000, 7'd0, 32'd8);
    expect_write("wrap1", 32'h00000000, 32'h0080A103);
    tick();
    chk("p5_done", {31'd0, done}, 32'd1);

    // Program 6: zero length
    do_start(32'h500, 16'd0);
    chk("len0_we0", {31'd0, imem_we}, 32'd0);
    chk("len0_rdy", {31'd0, in_ready}, 32'd0);
    chk("len0_done0", {31'd0, done}, 32'd0);
    tick();
    chk("len0_we1", {31'd0, imem_we}, 32'd0);
    chk("len0_done", {31'd0, done}, 32'd1);

    // Program 7: reset after the first handshake
    do_start(32'h600, 16'd4);
    op_class = 3'd1; rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; funct7 = 7'd0; imm = 32'd5;
    in_valid = 1'b1;
    tick();
    expect_write("mid", 32'h600, 32'h00500093);
    rst_n = 1'b0;
    #1;
    expect_idle_outputs("midrst");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst_we%0d", i), {31'd0, imem_we}, 32'd0);
      chk($sformatf("post_rst_rdy%0d", i), {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;

    // Recovery after reset
    do_start(32'h700, 16'd1);
    send("rec", 3'd6, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8);
    expect_write("rec", 32'h700, 32'h008000EF);
    tick();
    chk("rec_done", {31'd0, done}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
